// File: rtl/gppcu_instr_dispatcher_pkg.sv
// Shared definitions for the GPPCU instruction dispatcher.
//   DISP_DBW        - default instruction width (matches the core instruction width)
//   DISP_DEPTH      - default instruction buffer depth (power of two)
//   DISP_PIPE_DEPTH - default number of core pipeline stages to drain (F,D,E,W)
//   disp_state_t    - dispatcher FSM state encoding
package gppcu_instr_dispatcher_pkg;

   localparam int DISP_DBW        = 32;
   localparam int DISP_DEPTH      = 256;
   localparam int DISP_PIPE_DEPTH = 4;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PRIME = 3'd1,
      ISSUE = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } disp_state_t;

endpackage

// File: rtl/gppcu_instr_buf.sv
// Instruction buffer: DEPTH x DBW simple dual-port synchronous RAM.
// The host writes through the write port; the dispatcher reads through the read
// port with one cycle of latency. Contents are not affected by reset.
// Ports:
//   clk      in   1    clock
//   wr_en    in   1    write strobe
//   wr_addr  in   AW   write address
//   wr_data  in   DBW  write data
//   rd_en    in   1    read strobe
//   rd_addr  in   AW   read address
//   rd_data  out  DBW  read data, valid the cycle after rd_en
module gppcu_instr_buf
   import gppcu_instr_dispatcher_pkg::*;
#(
   parameter int DBW   = DISP_DBW,
   parameter int DEPTH = DISP_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic           clk,
   input  logic           wr_en,
   input  logic [AW-1:0]  wr_addr,
   input  logic [DBW-1:0] wr_data,
   input  logic           rd_en,
   input  logic [AW-1:0]  rd_addr,
   output logic [DBW-1:0] rd_data
);

   logic [DBW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/gppcu_instr_dispatcher.sv
// GPPCU instruction dispatcher: issuing end of the core instruction handshake.
// The host loads a kernel into the local buffer, pulses iSTART with iLEN; the
// block streams entries 0..len-1 to the core under valid/ready flow control,
// waits PIPE_DEPTH ready cycles for the core pipeline to drain, then pulses oDONE.
// Ports:
//   iACLK         in   1     clock, rising edge
//   iRST          in   1     synchronous active-high reset
//   iHOST_WR      in   1     buffer write strobe (accepted only while idle)
//   iHOST_ADDR    in   AW    buffer write address
//   iHOST_WDATA   in   DBW   buffer write data
//   iSTART        in   1     start pulse, sampled only while idle
//   iLEN          in   AW+1  instruction count 0..DEPTH (larger values clamp)
//   iABORT        in   1     cancel the running kernel
//   oBUSY         out  1     high whenever not idle
//   oDONE         out  1     one-cycle completion pulse
//   oPC           out  AW    buffer index of the word on oINSTR
//   oINSTR        out  DBW   instruction to the core
//   oINSTR_VALID  out  1     instruction valid to the core
//   iINSTR_READY  in   1     core ready
module gppcu_instr_dispatcher
   import gppcu_instr_dispatcher_pkg::*;
#(
   parameter int DBW        = DISP_DBW,
   parameter int DEPTH      = DISP_DEPTH,
   parameter int AW         = $clog2(DEPTH),
   parameter int PIPE_DEPTH = DISP_PIPE_DEPTH
) (
   input  logic           iACLK,
   input  logic           iRST,
   input  logic           iHOST_WR,
   input  logic [AW-1:0]  iHOST_ADDR,
   input  logic [DBW-1:0] iHOST_WDATA,
   input  logic           iSTART,
   input  logic [AW:0]    iLEN,
   input  logic           iABORT,
   output logic           oBUSY,
   output logic           oDONE,
   output logic [AW-1:0]  oPC,
   output logic [DBW-1:0] oINSTR,
   output logic           oINSTR_VALID,
   input  logic           iINSTR_READY
);

   localparam int CW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

   disp_state_t    state, state_nxt;

   logic [AW:0]    len_q;
   logic [AW:0]    rd_idx;
   logic           rd_en;
   logic [DBW-1:0] ram_rdata;

   logic           rd_vld_p1;
   logic [AW-1:0]  rd_pc_p1;

   logic           out_vld_p2;
   logic [DBW-1:0] out_data_p2;
   logic [AW-1:0]  out_pc_p2;
   logic           skid_vld_p2;
   logic [DBW-1:0] skid_data_p2;
   logic [AW-1:0]  skid_pc_p2;

   logic [CW-1:0]  drain_cnt;
   logic [1:0]     occ;
   logic           credit;
   logic           pop;
   logic           last_acc;
   logic           abort_now;
   logic           host_wr_en;

   function automatic logic [AW:0] clamp_len(input logic [AW:0] len);
      if (len > (AW+1)'(DEPTH)) begin
         return (AW+1)'(DEPTH);
      end
      return len;
   endfunction

   assign pop        = out_vld_p2 && iINSTR_READY;
   assign abort_now  = iABORT && (state != IDLE);
   assign last_acc   = pop && ({1'b0, out_pc_p2} == (len_q - (AW+1)'(1)));
   assign host_wr_en = iHOST_WR && (state == IDLE);

   // Words held or in flight: output reg + skid reg + outstanding RAM read.
   // A new read is only issued if it is guaranteed a slot when it lands.
   assign occ    = {1'b0, out_vld_p2} + {1'b0, skid_vld_p2} + {1'b0, rd_vld_p1};
   assign credit = (occ < 2'd2) || ((occ == 2'd2) && pop);

   gppcu_instr_buf #(
      .DBW   (DBW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_buf (
      .clk     (iACLK),
      .wr_en   (host_wr_en),
      .wr_addr (iHOST_ADDR),
      .wr_data (iHOST_WDATA),
      .rd_en   (rd_en),
      .rd_addr (rd_idx[AW-1:0]),
      .rd_data (ram_rdata)
   );

   always_ff @(posedge iACLK) begin
      if (iRST) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      oBUSY     = (state != IDLE);
      oDONE     = 1'b0;
      rd_en     = 1'b0;
      unique case (state)
         IDLE: begin
            if (iSTART) begin
               state_nxt = (clamp_len(iLEN) == '0) ? DONE : PRIME;
            end
         end
         PRIME: begin
            state_nxt = ISSUE;
         end
         ISSUE: begin
            if (last_acc) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (iINSTR_READY && (drain_cnt == CW'(PIPE_DEPTH - 1))) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            oDONE     = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      if ((state == PRIME) || (state == ISSUE)) begin
         rd_en = !iABORT && (rd_idx < len_q) && credit;
      end
      if (abort_now) begin
         state_nxt = IDLE;
      end
   end

   // Stage p1: RAM read address / read-valid tracking
   always_ff @(posedge iACLK) begin
      if (iRST) begin
         len_q     <= '0;
         rd_idx    <= '0;
         rd_vld_p1 <= 1'b0;
         drain_cnt <= '0;
      end else begin
         if ((state == IDLE) && iSTART) begin
            len_q  <= clamp_len(iLEN);
            rd_idx <= '0;
         end else if (rd_en) begin
            rd_idx <= rd_idx + (AW+1)'(1);
         end
         rd_vld_p1 <= rd_en && !abort_now;
         // Core stalls freeze its pipeline, so only ready cycles drain it.
         if (state != DRAIN) begin
            drain_cnt <= '0;
         end else if (iINSTR_READY) begin
            drain_cnt <= drain_cnt + CW'(1);
         end
      end
   end

   always_ff @(posedge iACLK) begin
      if (rd_en) begin
         rd_pc_p1 <= rd_idx[AW-1:0];
      end
   end

   // Stage p2: output register (head) plus skid register (second entry)
   always_ff @(posedge iACLK) begin
      if (iRST) begin
         out_vld_p2  <= 1'b0;
         skid_vld_p2 <= 1'b0;
         out_data_p2 <= '0;
         out_pc_p2   <= '0;
      end else if (abort_now) begin
         out_vld_p2  <= 1'b0;
         skid_vld_p2 <= 1'b0;
      end else if (rd_vld_p1) begin
         if (!out_vld_p2 || pop) begin
            if (skid_vld_p2) begin
               out_data_p2  <= skid_data_p2;
               out_pc_p2    <= skid_pc_p2;
               skid_data_p2 <= ram_rdata;
               skid_pc_p2   <= rd_pc_p1;
            end else begin
               out_data_p2 <= ram_rdata;
               out_pc_p2   <= rd_pc_p1;
               out_vld_p2  <= 1'b1;
            end
         end else begin
            skid_data_p2 <= ram_rdata;
            skid_pc_p2   <= rd_pc_p1;
            skid_vld_p2  <= 1'b1;
         end
      end else if (pop) begin
         if (skid_vld_p2) begin
            out_data_p2 <= skid_data_p2;
            out_pc_p2   <= skid_pc_p2;
            skid_vld_p2 <= 1'b0;
         end else begin
            out_vld_p2 <= 1'b0;
         end
      end
   end

   assign oINSTR_VALID = out_vld_p2;
   assign oINSTR       = out_data_p2;
   assign oPC          = out_pc_p2;

endmodule

// File: tb/tb_gppcu_instr_dispatcher.sv
// Self-checking bench for gppcu_instr_dispatcher: directed kernel runs with a
// shadow copy of the instruction buffer and a core-side monitor that records
// every accepted (pc, instruction) pair.
module tb_gppcu_instr_dispatcher;

   localparam int DBW        = 32;
   localparam int DEPTH      = 256;
   localparam int AW         = 8;
   localparam int PIPE_DEPTH = 4;

   logic           iACLK;
   logic           iRST;
   logic           iHOST_WR;
   logic [AW-1:0]  iHOST_ADDR;
   logic [DBW-1:0] iHOST_WDATA;
   logic           iSTART;
   logic [AW:0]    iLEN;
   logic           iABORT;
   logic           oBUSY;
   logic           oDONE;
   logic [AW-1:0]  oPC;
   logic [DBW-1:0] oINSTR;
   logic           oINSTR_VALID;
   logic           iINSTR_READY;

   gppcu_instr_dispatcher #(
      .DBW        (DBW),
      .DEPTH      (DEPTH),
      .AW         (AW),
      .PIPE_DEPTH (PIPE_DEPTH)
   ) dut (
      .iACLK        (iACLK),
      .iRST         (iRST),
      .iHOST_WR     (iHOST_WR),
      .iHOST_ADDR   (iHOST_ADDR),
      .iHOST_WDATA  (iHOST_WDATA),
      .iSTART       (iSTART),
      .iLEN         (iLEN),
      .iABORT       (iABORT),
      .oBUSY        (oBUSY),
      .oDONE        (oDONE),
      .oPC          (oPC),
      .oINSTR       (oINSTR),
      .oINSTR_VALID (oINSTR_VALID),
      .iINSTR_READY (iINSTR_READY)
   );

   typedef struct packed {
      logic [AW-1:0]  pc;
      logic [DBW-1:0] instr;
   } acc_t;

   int             n_cmp = 0;
   int             n_err = 0;
   int             cyc = 0;
   logic [DBW-1:0] shadow [DEPTH];
   acc_t           acc_q [$];
   int             done_cnt = 0;
   int             done_cyc = 0;
   int             busy_cnt = 0;
   int             valid_cnt = 0;
   int             start_cyc = 0;
   int             fv_cyc = -1;
   int             last_acc_cyc = 0;
   int             post_cnt = 0;
   bit             track = 0;
   bit             hold_pend = 0;
   acc_t           hold_val;
   int             rdy_mode = 0;
   int             stall_left = 0;

   initial begin
      iACLK = 1'b0;
      forever #5 iACLK = ~iACLK;
   end

   initial forever begin
      @(posedge iACLK);
      cyc++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge iACLK);
      #1;
   endtask

   // Core-side ready: tied high, random, or a 3-cycle stall while entry 1 is shown.
   initial begin
      iINSTR_READY = 1'b1;
      forever begin
         @(posedge iACLK);
         #1;
         case (rdy_mode)
            1: iINSTR_READY = ($urandom_range(0, 3) != 0);
            2: begin
               if (oINSTR_VALID && (oPC == AW'(1)) && (stall_left > 0)) begin
                  iINSTR_READY = 1'b0;
                  stall_left--;
               end else begin
                  iINSTR_READY = 1'b1;
               end
            end
            default: iINSTR_READY = 1'b1;
         endcase
      end
   end

   // Core-side monitor, sampled mid-cycle.
   initial forever begin
      @(negedge iACLK);
      if (iSTART && !oBUSY && !iRST) begin
         start_cyc = cyc;
         fv_cyc    = -1;
         track     = 0;
      end
      if (oBUSY) busy_cnt++;
      if (oINSTR_VALID) begin
         valid_cnt++;
         if (fv_cyc < 0) fv_cyc = cyc;
         chk("instr_matches_buffer", oINSTR, shadow[oPC]);
      end
      if (hold_pend) begin
         chk("hold_valid", oINSTR_VALID, 1);
         chk("hold_word", {oPC, oINSTR}, hold_val);
      end
      hold_pend = oINSTR_VALID && !iINSTR_READY && !iABORT && !iRST;
      hold_val  = {oPC, oINSTR};
      if (oDONE) begin
         done_cnt++;
         done_cyc = cyc;
         // Done follows the PIPE_DEPTH-th ready-high cycle after the final accept.
         if (track) chk("drain_ready_cycles", post_cnt, PIPE_DEPTH);
         track = 0;
      end else if (track && iINSTR_READY) begin
         post_cnt++;
      end
      if (oINSTR_VALID && iINSTR_READY) begin
         acc_q.push_back({oPC, oINSTR});
         last_acc_cyc = cyc;
         track        = 1;
         post_cnt     = 0;
      end
   end

   task automatic host_write(input int a, input logic [DBW-1:0] d, input bit lands);
      iHOST_WR    = 1'b1;
      iHOST_ADDR  = AW'(a);
      iHOST_WDATA = d;
      tick();
      iHOST_WR = 1'b0;
      if (lands) shadow[a] = d;
   endtask

   task automatic kick(input int len);
      iSTART = 1'b1;
      iLEN   = (AW+1)'(len);
      tick();
      iSTART = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int budget, input string tag);
      for (int i = 0; i < budget && done_cnt == d0; i++) tick();
      chk({tag, "_done_pulses"}, done_cnt - d0, 1);
      tick();
   endtask

   task automatic check_stream(input int len, input string tag);
      int n;
      n = (len > DEPTH) ? DEPTH : len;
      chk({tag, "_accept_count"}, acc_q.size(), n);
      for (int i = 0; i < n && i < acc_q.size(); i++) begin
         chk({tag, "_entry"}, acc_q[i], {AW'(i), shadow[i]});
      end
   endtask

   task automatic run_kernel(input int len, input int budget, input string tag);
      int d0;
      d0 = done_cnt;
      acc_q.delete();
      kick(len);
      wait_done(d0, budget, tag);
      check_stream(len, tag);
   endtask

   initial begin
      int d0, b0, v0;
      iRST = 1'b1; iHOST_WR = 1'b0; iHOST_ADDR = '0; iHOST_WDATA = '0;
      iSTART = 1'b0; iLEN = '0; iABORT = 1'b0;
      repeat (3) tick();
      chk("rst_busy",  oBUSY, 0);
      chk("rst_done",  oDONE, 0);
      chk("rst_valid", oINSTR_VALID, 0);
      chk("rst_pc",    oPC, 0);
      chk("rst_instr", oINSTR, 0);
      iRST = 1'b0;
      tick();

      // 1: four-instruction program, ready tied high
      host_write(0, 32'h11, 1);
      host_write(1, 32'h22, 1);
      host_write(2, 32'h33, 1);
      host_write(3, 32'h44, 1);
      run_kernel(4, 100, "t1");
      chk("t1_first_valid_cycle", fv_cyc, start_cyc + 3);
      chk("t1_done_latency", done_cyc - last_acc_cyc, PIPE_DEPTH + 1);

      // 2: ready low for 3 cycles while entry 1 is presented
      stall_left = 3;
      rdy_mode   = 2;
      run_kernel(4, 100, "t2");
      rdy_mode   = 0;

      // host write and start in the same cycle: kernel sees new data
      d0 = done_cnt;
      acc_q.delete();
      iHOST_WR = 1'b1; iHOST_ADDR = '0; iHOST_WDATA = 32'h55;
      iSTART = 1'b1; iLEN = (AW+1)'(4);
      tick();
      iHOST_WR = 1'b0; iSTART = 1'b0;
      shadow[0] = 32'h55;
      wait_done(d0, 100, "t2b");
      check_stream(4, "t2b");

      // 3: zero-length kernel
      d0 = done_cnt; b0 = busy_cnt; v0 = valid_cnt;
      kick(0);
      repeat (4) tick();
      chk("t3_busy_cycles", busy_cnt - b0, 1);
      chk("t3_done_pulses", done_cnt - d0, 1);
      chk("t3_done_cycle", done_cyc, start_cyc + 1);
      chk("t3_valid_cycles", valid_cnt - v0, 0);

      // 4: full buffer with random ready, then an over-range length
      for (int i = 0; i < DEPTH; i++) host_write(i, $urandom, 1);
      rdy_mode = 1;
      run_kernel(DEPTH, 3000, "t4");
      if (acc_q.size() > 0) chk("t4_last_pc", acc_q[acc_q.size()-1].pc, DEPTH - 1);
      else chk("t4_last_pc", 0, DEPTH - 1);
      rdy_mode = 0;
      run_kernel(400, 1000, "t4_clamp");

      // 5: abort after two accepts, then restart from entry 0
      d0 = done_cnt;
      acc_q.delete();
      kick(4);
      for (int i = 0; i < 50 && acc_q.size() < 2; i++) tick();
      iABORT = 1'b1;
      tick();
      iABORT = 1'b0;
      chk("t5_valid_after_abort", oINSTR_VALID, 0);
      chk("t5_busy_after_abort", oBUSY, 0);
      repeat (8) tick();
      chk("t5_no_done", done_cnt - d0, 0);
      chk("t5_accepts", acc_q.size(), 3);
      for (int i = 0; i < 3 && i < acc_q.size(); i++) begin
         chk("t5_entry", acc_q[i], {AW'(i), shadow[i]});
      end
      run_kernel(4, 100, "t5_restart");

      // 6: host write while busy is ignored
      d0 = done_cnt;
      acc_q.delete();
      kick(4);
      tick();
      host_write(1, 32'hDEAD_BEEF, 0);
      wait_done(d0, 100, "t6");
      check_stream(4, "t6");
      run_kernel(4, 100, "t6_readback");

      // reset in the middle of DRAIN
      d0 = done_cnt;
      acc_q.delete();
      kick(4);
      for (int i = 0; i < 50 && acc_q.size() < 4; i++) tick();
      tick();
      iRST = 1'b1;
      tick();
      iRST = 1'b0;
      chk("t6_rst_busy",  oBUSY, 0);
      chk("t6_rst_done",  oDONE, 0);
      chk("t6_rst_valid", oINSTR_VALID, 0);
      chk("t6_rst_pc",    oPC, 0);
      chk("t6_rst_instr", oINSTR, 0);
      repeat (10) tick();
      chk("t6_rst_no_done", done_cnt - d0, 0);
      run_kernel(4, 100, "t6_after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
